// File: rtl/stage_judge_if.sv
// rtl/stage_judge_if.sv - Judge request/response bundle between game FSM and stage judge.
interface stage_judge_if;
    logic         start;
    logic         restart;
    logic [63:0]  wall;
    logic [63:0]  destination;
    logic [133:0] game_state;
    logic [1:0]   stage;
    logic         busy;
    logic         done;
    logic         win;
    logic         illegal;
    logic         all_clear;
    logic         load_stage;

    modport master (
        output start, restart, wall, destination, game_state,
        input  stage, busy, done, win, illegal, all_clear, load_stage
    );

    modport slave (
        input  start, restart, wall, destination, game_state,
        output stage, busy, done, win, illegal, all_clear, load_stage
    );
endinterface

// File: rtl/stage_judge.sv
// rtl/stage_judge.sv - Sequential 64-cell win/illegal judge with stage advance and reload request.
module stage_judge #(
    parameter int NUM_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    stage_judge_if.slave  jif
);
    typedef enum logic [1:0] {IDLE, SCAN, REPORT, ADVANCE} state_t;

    localparam logic [1:0] LAST_STAGE = 2'(NUM_STAGES - 1);

    state_t      state, state_next;
    logic        accept_start, accept_restart;

    logic [63:0] box_q, dest_q, wall_q;
    logic [5:0]  man_q;
    logic [5:0]  idx;
    logic        miss, bad, ndest;
    logic        judge_win;

    logic [1:0]  stage_q;
    logic        busy_q, done_q, win_q, illegal_q, all_clear_q, load_q;

    logic        cell_box, cell_dest, cell_wall, cell_is_man;
    logic        unused_reserved;

    assign unused_reserved = ^jif.game_state[69:6];

    // Latched maps are shifted right each SCAN cycle, so bit 0 is always cell idx.
    assign cell_box    = box_q[0];
    assign cell_dest   = dest_q[0];
    assign cell_wall   = wall_q[0];
    assign cell_is_man = (idx == man_q);

    assign judge_win = ~miss & ~bad & ndest;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        accept_start   = 1'b0;
        accept_restart = 1'b0;
        case (state)
            IDLE: begin
                if (jif.restart) begin
                    accept_restart = 1'b1;
                end else if (jif.start && !all_clear_q) begin
                    accept_start = 1'b1;
                    state_next   = SCAN;
                end
            end
            SCAN: begin
                if (idx == 6'd63) begin
                    state_next = REPORT;
                end
            end
            REPORT: begin
                state_next = judge_win ? ADVANCE : IDLE;
            end
            ADVANCE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // All visible outputs are registered, so they trail the state by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            box_q       <= '0;
            dest_q      <= '0;
            wall_q      <= '0;
            man_q       <= '0;
            idx         <= '0;
            miss        <= 1'b0;
            bad         <= 1'b0;
            ndest       <= 1'b0;
            stage_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            win_q       <= 1'b0;
            illegal_q   <= 1'b0;
            all_clear_q <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            busy_q <= (state == SCAN) || (state == REPORT);
            done_q <= (state == REPORT);
            load_q <= accept_restart || ((state == ADVANCE) && (stage_q != LAST_STAGE));

            if (accept_start) begin
                box_q     <= jif.game_state[133:70];
                dest_q    <= jif.destination;
                wall_q    <= jif.wall;
                man_q     <= {jif.game_state[2:0], jif.game_state[5:3]};
                idx       <= '0;
                miss      <= 1'b0;
                bad       <= 1'b0;
                ndest     <= 1'b0;
                win_q     <= 1'b0;
                illegal_q <= 1'b0;
            end

            if (state == SCAN) begin
                miss   <= miss  | (cell_dest & ~cell_box);
                bad    <= bad   | (cell_box & cell_wall) | (cell_is_man & (cell_box | cell_wall));
                ndest  <= ndest | cell_dest;
                box_q  <= box_q  >> 1;
                dest_q <= dest_q >> 1;
                wall_q <= wall_q >> 1;
                idx    <= idx + 6'd1;
            end

            if (state == REPORT) begin
                win_q     <= judge_win;
                illegal_q <= bad;
            end

            if (state == ADVANCE) begin
                if (stage_q != LAST_STAGE) begin
                    stage_q <= stage_q + 2'd1;
                end else begin
                    all_clear_q <= 1'b1;
                end
            end
        end
    end

    assign jif.stage      = stage_q;
    assign jif.busy       = busy_q;
    assign jif.done       = done_q;
    assign jif.win        = win_q;
    assign jif.illegal    = illegal_q;
    assign jif.all_clear  = all_clear_q;
    assign jif.load_stage = load_q;
endmodule

// File: tb/tb_stage_judge.sv
// tb/tb_stage_judge.sv - Randomized self-checking bench for stage_judge against a map-level model.
module tb_stage_judge;
    localparam int NS = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stage_judge_if jif();

    stage_judge #(.NUM_STAGES(NS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .jif   (jif)
    );

    int tests  = 0;
    int failed = 0;
    int exp_stage = 0;
    bit exp_all_clear = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] out_vec();
        return {jif.stage, jif.busy, jif.done, jif.win, jif.illegal, jif.all_clear} == 0 && !jif.load_stage
               ? 7'd0 : {jif.stage, jif.busy, jif.done, jif.win, jif.illegal, jif.all_clear, jif.load_stage};
    endfunction

    // Reference: whole-map rules, no notion of scan order.
    task automatic model(input logic [63:0] box, dest, wall, input int man, output bit w, output bit ill);
        bit bad_m, miss_m;
        bad_m  = ((box & wall) != 0) || box[man] || wall[man];
        miss_m = ((dest & ~box) != 0);
        w      = !miss_m && !bad_m && (dest != 0);
        ill    = bad_m;
    endtask

    task automatic drive_state(input logic [63:0] box, dest, wall, input logic [2:0] mx, my);
        jif.wall        = wall;
        jif.destination = dest;
        jif.game_state  = {box, {$urandom, $urandom}, mx, my};
    endtask

    task automatic judge(input logic [63:0] box, dest, wall, input logic [2:0] mx, my,
                         input bit scramble, input int poke, input string tag);
        bit ew, ei, win_seen, ill_seen;
        int done_cycle, done_count, busy_bad, load_count, load_cycle, exp_loads;
        model(box, dest, wall, int'(my) * 8 + int'(mx), ew, ei);
        @(negedge clk);
        drive_state(box, dest, wall, mx, my);
        jif.start = 1'b1;
        @(negedge clk);
        jif.start = 1'b0;
        if (scramble) drive_state({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                                  3'($urandom), 3'($urandom));
        done_cycle = -1; done_count = 0; busy_bad = 0; load_count = 0; load_cycle = -1;
        win_seen = 0; ill_seen = 0;
        for (int c = 0; c <= 68; c++) begin
            if (jif.done) begin
                done_count++;
                if (done_cycle < 0) begin
                    done_cycle = c; win_seen = jif.win; ill_seen = jif.illegal;
                end
            end
            if (jif.busy !== (c >= 1 && c <= 65)) busy_bad++;
            if (jif.load_stage) begin load_count++; load_cycle = c; end
            jif.start = (c == poke);
            @(negedge clk);
        end
        check({tag, " done_cycle"}, 64'(done_cycle), 64'd65);
        check({tag, " done_count"}, 64'(done_count), 64'd1);
        check({tag, " busy_window"}, 64'(busy_bad), 64'd0);
        check({tag, " win"}, 64'(win_seen), 64'(ew));
        check({tag, " illegal"}, 64'(ill_seen), 64'(ei));
        exp_loads = 0;
        if (ew) begin
            if (exp_stage < NS - 1) begin
                exp_stage++;
                exp_loads = 1;
            end else begin
                exp_all_clear = 1'b1;
            end
        end
        check({tag, " load_count"}, 64'(load_count), 64'(exp_loads));
        if (exp_loads == 1) check({tag, " load_cycle"}, 64'(load_cycle), 64'd66);
        check({tag, " stage"}, 64'(jif.stage), 64'(exp_stage));
        check({tag, " all_clear"}, 64'(jif.all_clear), 64'(exp_all_clear));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check({tag, " outputs_in_reset"}, 64'(out_vec()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_stage = 0;
        exp_all_clear = 1'b0;
    endtask

    task automatic restart_pulse(input bit with_start, input string tag);
        @(negedge clk);
        jif.restart = 1'b1;
        jif.start   = with_start;
        @(negedge clk);
        jif.restart = 1'b0;
        jif.start   = 1'b0;
        check({tag, " load_on"}, 64'(jif.load_stage), 64'd1);
        check({tag, " busy0"}, 64'(jif.busy), 64'd0);
        @(negedge clk);
        check({tag, " load_off"}, 64'(jif.load_stage), 64'd0);
        check({tag, " busy1"}, 64'(jif.busy), 64'd0);
        check({tag, " stage"}, 64'(jif.stage), 64'(exp_stage));
    endtask

    task automatic reset_mid_scan();
        int done_count, load_count;
        @(negedge clk);
        drive_state(64'h1, 64'h1, 64'h0, 3'd3, 3'd3);
        jif.start = 1'b1;
        @(negedge clk);
        jif.start = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid outputs", 64'(out_vec()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_stage = 0;
        exp_all_clear = 1'b0;
        done_count = 0; load_count = 0;
        for (int c = 0; c < 80; c++) begin
            if (jif.done) done_count++;
            if (jif.load_stage || jif.busy) load_count++;
            @(negedge clk);
        end
        check("rst_mid no_done", 64'(done_count), 64'd0);
        check("rst_mid quiet", 64'(load_count), 64'd0);
    endtask

    task automatic start_ignored(input string tag);
        int activity;
        @(negedge clk);
        drive_state(64'h1, 64'h1, 64'h0, 3'd3, 3'd3);
        jif.start = 1'b1;
        @(negedge clk);
        jif.start = 1'b0;
        activity = 0;
        for (int c = 0; c < 70; c++) begin
            if (jif.busy || jif.done) activity++;
            @(negedge clk);
        end
        check({tag, " no_activity"}, 64'(activity), 64'd0);
    endtask

    initial begin
        logic [63:0] box, dest, wall;
        int m, mode;
        rst_n = 1'b0;
        jif.start = 1'b0;
        jif.restart = 1'b0;
        jif.wall = '0;
        jif.destination = '0;
        jif.game_state = '0;
        repeat (3) @(negedge clk);
        check("reset outputs", 64'(out_vec()), 64'd0);
        rst_n = 1'b1;

        judge(64'h1, 64'h1, 64'h8000_0000_0000_0000, 3'd1, 3'd0, 0, -1, "win_advance");
        judge(64'h2, 64'h1, 64'h0, 3'd5, 3'd0, 0, -1, "miss");
        judge(64'h3, 64'h3, 64'h2, 3'd2, 3'd1, 0, -1, "illegal_wall");
        judge(64'h1, 64'h1, 64'h0, 3'd0, 3'd0, 0, -1, "illegal_man");
        judge(64'h0, 64'h0, 64'h0, 3'd4, 3'd4, 0, -1, "no_dest");
        restart_pulse(1'b1, "collision");
        judge(64'h2, 64'h1, 64'h0, 3'd5, 3'd0, 1, 10, "busy_start");
        reset_mid_scan();

        for (int t = 0; t < 24; t++) begin
            if (exp_all_clear) do_reset("rand_reset");
            box  = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            mode = $urandom_range(0, 2);
            m    = $urandom_range(0, 63);
            if (mode == 0) begin
                dest = box;
                wall = {$urandom, $urandom} & {$urandom, $urandom} & ~box;
                for (int k = 0; k < 64; k++) begin
                    if (!box[m] && !wall[m]) break;
                    m = $urandom_range(0, 63);
                end
            end else if (mode == 1) begin
                dest = {$urandom, $urandom} & {$urandom, $urandom};
                wall = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            end else begin
                dest = '0;
                wall = '0;
            end
            judge(box, dest, wall, 3'(m % 8), 3'(m / 8), $urandom_range(0, 1), -1, $sformatf("rand%0d", t));
        end

        do_reset("last_reset");
        judge(64'h10, 64'h10, 64'h0, 3'd0, 3'd0, 0, -1, "last_win0");
        judge(64'h10, 64'h10, 64'h0, 3'd0, 3'd0, 1, -1, "last_win1");
        start_ignored("cleared");
        restart_pulse(1'b0, "cleared_restart");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
